// File: rtl/rom_arb.sv
// Two-port round-robin arbiter in front of a single-cycle-latency ROM.
// Fetch (i_*) and data (d_*) ports share one response path with a hold register for stalls.
module rom_arb #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    input  logic              i_rready,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_gnt,
    output logic              d_rvalid,
    input  logic              d_rready,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout
);

    typedef enum logic [1:0] {IDLE, RESP, HOLD} state_t;

    state_t            state_reg;
    logic              owner_reg;   // 1 = data port owns the outstanding response
    logic              last_reg;    // 1 = data port was granted most recently
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] hold_reg;

    logic owner_rready;
    logic can_issue;
    logic pick_d;
    logic any_gnt;

    always_comb begin
        owner_rready = owner_reg ? d_rready : i_rready;
        can_issue    = (state_reg == IDLE) || owner_rready;
        pick_d       = d_req && (!i_req || !last_reg);
        // Gated by rst_n so grants drop the instant reset asserts.
        i_gnt        = rst_n && can_issue && i_req && !pick_d;
        d_gnt        = rst_n && can_issue && pick_d;
        any_gnt      = i_gnt || d_gnt;
    end

    assign rom_addr = d_gnt ? d_addr : (i_gnt ? i_addr : addr_reg);

    always_comb begin
        i_rvalid = (state_reg != IDLE) && !owner_reg;
        d_rvalid = (state_reg != IDLE) && owner_reg;
        rdata    = '0;
        if (state_reg == RESP)
            rdata = rom_dout;
        else if (state_reg == HOLD)
            rdata = hold_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            owner_reg <= 1'b0;
            last_reg  <= 1'b1;
            addr_reg  <= '0;
            hold_reg  <= '0;
        end else begin
            if (any_gnt) begin
                state_reg <= RESP;
                owner_reg <= d_gnt;
                last_reg  <= d_gnt;
                addr_reg  <= rom_addr;
            end else begin
                case (state_reg)
                    RESP: begin
                        if (owner_rready) begin
                            state_reg <= IDLE;
                        end else begin
                            state_reg <= HOLD;
                            hold_reg  <= rom_dout;
                        end
                    end
                    HOLD: begin
                        if (owner_rready)
                            state_reg <= IDLE;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rom_arb.sv
// Bench for rom_arb: behavioural ROM, grant/response scoreboard and per-scenario tasks.
module tb_rom_arb;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_req = 1'b0, d_req = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0, d_addr = '0;
    logic              i_rready = 1'b0, d_rready = 1'b0;
    logic              i_gnt, d_gnt, i_rvalid, d_rvalid;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_dout = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic              port;   // 1 = data
        logic [DATA_W-1:0] data;
        int                gcyc;
        bit                seen;
    } sb_entry_t;
    sb_entry_t sb[$];

    rom_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rready(i_rready),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rready(d_rready),
        .rdata(rdata), .rom_addr(rom_addr), .rom_dout(rom_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] rom_model(input logic [ADDR_W-1:0] a);
        if (a == 10'h080) return 32'hDEADC1B7;
        if (a == 10'h15C) return 32'h00FF00FF;
        return {22'h2A5A5A, a} ^ 32'h1357_0000;
    endfunction

    always @(posedge clk) begin
        rom_dout <= rom_model(rom_addr);
        cyc      <= cyc + 1;
    end

    // Scoreboard: grants push expectations, responses pop and compare.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            total++;
            if (i_gnt && d_gnt) begin
                bad++;
                $display("FAIL two_gnt: i_gnt=%b d_gnt=%b required at most one", i_gnt, d_gnt);
            end
            total++;
            if (i_rvalid && d_rvalid) begin
                bad++;
                $display("FAIL two_rvalid: i_rvalid=%b d_rvalid=%b required at most one", i_rvalid, d_rvalid);
            end
            if (i_rvalid || d_rvalid) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: rvalid i=%b d=%b with nothing outstanding", i_rvalid, d_rvalid);
                end else begin
                    if (d_rvalid !== sb[0].port || rdata !== sb[0].data) begin
                        bad++;
                        $display("FAIL sb_resp: got port=%b rdata=%h required port=%b rdata=%h",
                                 d_rvalid, rdata, sb[0].port, sb[0].data);
                    end
                    if (!sb[0].seen) begin
                        total++;
                        if (cyc != sb[0].gcyc + 1) begin
                            bad++;
                            $display("FAIL sb_latency: got %0d cycles required 1", cyc - sb[0].gcyc);
                        end
                        sb[0].seen = 1'b1;
                    end
                    if ((i_rvalid && i_rready) || (d_rvalid && d_rready))
                        void'(sb.pop_front());
                end
            end else if (sb.size() > 0 && !sb[0].seen && cyc > sb[0].gcyc + 1) begin
                total++;
                bad++;
                $display("FAIL sb_missing: no rvalid at cycle %0d required after grant at %0d", cyc, sb[0].gcyc);
                void'(sb.pop_front());
            end
            if (i_gnt) sb.push_back('{1'b0, rom_model(i_addr), cyc, 1'b0});
            if (d_gnt) sb.push_back('{1'b1, rom_model(d_addr), cyc, 1'b0});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        i_req = 1'b1; d_req = 1'b1; i_addr = 10'h123; d_addr = 10'h321;
        rst_n = 1'b0;
        step();
        @(negedge clk);
        total++;
        if ({i_gnt, d_gnt, i_rvalid, d_rvalid} !== 4'b0 || rdata !== '0 || rom_addr !== '0) begin
            bad++;
            $display("FAIL reset_outputs: gnt=%b%b rvalid=%b%b rdata=%h rom_addr=%h required all 0",
                     i_gnt, d_gnt, i_rvalid, d_rvalid, rdata, rom_addr);
        end
        step();
        i_req = 1'b0; d_req = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_fetch();
        i_addr = 10'h080; i_req = 1'b1; i_rready = 1'b1;
        @(negedge clk);
        total++;
        if (i_gnt !== 1'b1 || d_gnt !== 1'b0 || rom_addr !== 10'h080) begin
            bad++;
            $display("FAIL fetch_gnt: i_gnt=%b d_gnt=%b rom_addr=%h required 1 0 080", i_gnt, d_gnt, rom_addr);
        end
        step();
        i_req = 1'b0;
        @(negedge clk);
        total++;
        if (i_rvalid !== 1'b1 || rdata !== 32'hDEADC1B7) begin
            bad++;
            $display("FAIL fetch_resp: i_rvalid=%b rdata=%h required 1 deadc1b7", i_rvalid, rdata);
        end
        step();
    endtask

    task automatic test_alternate();
        do_reset();
        i_req = 1'b1; d_req = 1'b1; i_rready = 1'b1; d_rready = 1'b1;
        i_addr = 10'h010; d_addr = 10'h2F0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            total++;
            if (i_gnt !== (k % 2 == 0) || d_gnt !== (k % 2 == 1)) begin
                bad++;
                $display("FAIL alt_gnt[%0d]: i_gnt=%b d_gnt=%b required %b %b",
                         k, i_gnt, d_gnt, k % 2 == 0, k % 2 == 1);
            end
            step();
            i_addr = i_addr + 10'h004;
            d_addr = d_addr - 10'h004;
        end
        i_req = 1'b0; d_req = 1'b0;
        step();
        step();
    endtask

    task automatic test_hold();
        d_req = 1'b1; d_addr = 10'h15C; d_rready = 1'b0; i_req = 1'b0; i_rready = 1'b1;
        @(negedge clk);
        total++;
        if (d_gnt !== 1'b1) begin
            bad++;
            $display("FAIL hold_gnt: d_gnt=%b required 1", d_gnt);
        end
        step();
        d_req = 1'b0; i_req = 1'b1; i_addr = 10'h040;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (d_rvalid !== 1'b1 || rdata !== 32'h00FF00FF || i_gnt !== 1'b0 || d_gnt !== 1'b0) begin
                bad++;
                $display("FAIL hold_stall[%0d]: d_rvalid=%b rdata=%h gnt=%b%b required 1 00ff00ff 00",
                         k, d_rvalid, rdata, i_gnt, d_gnt);
            end
            step();
        end
        i_req = 1'b0; d_rready = 1'b1;
        @(negedge clk);
        total++;
        if (d_rvalid !== 1'b1 || rdata !== 32'h00FF00FF) begin
            bad++;
            $display("FAIL hold_accept: d_rvalid=%b rdata=%h required 1 00ff00ff", d_rvalid, rdata);
        end
        step();
        i_req = 1'b1;
        @(negedge clk);
        total++;
        if (i_gnt !== 1'b1 || d_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL hold_resume: i_gnt=%b d_rvalid=%b required 1 0", i_gnt, d_rvalid);
        end
        step();
        i_req = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        d_req = 1'b1; d_addr = 10'h200; d_rready = 1'b1; i_rready = 1'b1;
        @(negedge clk);
        total++;
        if (d_gnt !== 1'b1) begin
            bad++;
            $display("FAIL b2b_dgnt: d_gnt=%b required 1", d_gnt);
        end
        step();
        d_req = 1'b0; i_req = 1'b1; i_addr = 10'h104;
        @(negedge clk);
        total++;
        if (i_gnt !== 1'b1 || d_rvalid !== 1'b1 || rdata !== rom_model(10'h200)) begin
            bad++;
            $display("FAIL b2b_overlap: i_gnt=%b d_rvalid=%b rdata=%h required 1 1 %h",
                     i_gnt, d_rvalid, rdata, rom_model(10'h200));
        end
        step();
        i_req = 1'b0;
        @(negedge clk);
        total++;
        if (i_rvalid !== 1'b1 || rdata !== rom_model(10'h104)) begin
            bad++;
            $display("FAIL b2b_second: i_rvalid=%b rdata=%h required 1 %h", i_rvalid, rdata, rom_model(10'h104));
        end
        step();
    endtask

    task automatic test_drop_req();
        int acc = 0;
        int dcnt = 0;
        i_req = 1'b1; i_addr = 10'h3FC; i_rready = 1'b0; d_req = 1'b0; d_rready = 1'b1;
        @(negedge clk);
        total++;
        if (i_gnt !== 1'b1) begin
            bad++;
            $display("FAIL drop_gnt: i_gnt=%b required 1", i_gnt);
        end
        step();
        i_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (i_rvalid && i_rready) acc++;
            if (d_rvalid) dcnt++;
            step();
            if (k == 0) i_rready = 1'b1;
        end
        total++;
        if (acc != 1 || dcnt != 0) begin
            bad++;
            $display("FAIL drop_deliver: fetch accepts=%0d data rvalids=%0d required 1 0", acc, dcnt);
        end
    endtask

    task automatic test_reset_hold();
        d_req = 1'b1; d_addr = 10'h15C; d_rready = 1'b0; i_req = 1'b0;
        step();
        d_req = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({i_gnt, d_gnt, i_rvalid, d_rvalid} !== 4'b0 || rdata !== '0 || rom_addr !== '0) begin
            bad++;
            $display("FAIL rst_async: gnt=%b%b rvalid=%b%b rdata=%h rom_addr=%h required all 0",
                     i_gnt, d_gnt, i_rvalid, d_rvalid, rdata, rom_addr);
        end
        step();
        step();
        rst_n = 1'b1;
        d_rready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
                bad++;
                $display("FAIL rst_norvalid[%0d]: rvalid=%b%b required 00", k, i_rvalid, d_rvalid);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_alternate();
        test_hold();
        test_back_to_back();
        test_drop_req();
        test_reset_hold();
        step();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: %0d responses outstanding required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/rom_arb.md
ROM_ARB -- requirements
Module: rom_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, ROM byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, ROM word width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports i_req  input  1, and i_addr  input  ADDR_W: instruction-fetch request and byte address.
REQ-006 SHALL have port i_gnt  output  1  fetch request accepted this cycle.
REQ-007 SHALL have ports i_rvalid  output  1, and i_rready  input  1: fetch response handshake.
REQ-008 SHALL have ports d_req  input  1, d_addr  input  ADDR_W, d_gnt  output  1, d_rvalid  output  1, d_rready  input  1: data-load port, same semantics as fetch port.
REQ-009 SHALL have port rdata  output  DATA_W  response word, shared; qualified by i_rvalid or d_rvalid.
REQ-010 SHALL have port rom_addr  output  ADDR_W  address to ROM; ROM returns the word on the next rising edge.
REQ-011 SHALL have port rom_dout  input  DATA_W  registered ROM read data.

Function
REQ-012 SHALL accept a request when req && gnt in the same cycle; gnt combinational from req, arbitration state and rready.
REQ-013 SHALL drive rom_addr from the granted port's address in the grant cycle; otherwise it holds the last granted address.
REQ-014 SHALL have states IDLE (no response outstanding), RESP (ROM word arriving this cycle) and HOLD (word captured, awaiting rready).
REQ-015 SHALL present rom_dout on rdata and assert the owner's rvalid in RESP, one cycle after grant (latency 1).
REQ-016 SHALL, in RESP with owner rready=0, capture rom_dout into a hold register and enter HOLD; rdata then comes from the hold register.
REQ-017 SHALL keep rvalid and rdata stable in HOLD until owner rready=1, then leave HOLD.
REQ-018 SHALL issue grants only when can_issue = (IDLE) or (RESP and owner rready=1) or (HOLD and owner rready=1).
REQ-019 SHALL therefore sustain one grant per cycle while responses are accepted immediately.
REQ-020 SHALL transition to RESP on any grant and to IDLE when the response is accepted with no new grant.
REQ-021 SHALL arbitrate round-robin: with both req high, grant the port not granted most recently; with one req high, grant it.
REQ-022 SHALL update the last-granted pointer only on an accepted grant.
REQ-023 SHALL assert at most one gnt and at most one rvalid per cycle.
REQ-024 SHALL ignore addr[1:0] (word access); the ROM sees the full address unchanged.
REQ-025 SHALL allow the owner to deassert req after grant without affecting the outstanding response.
REQ-026 SHALL keep gnt low while can_issue is low, even if req is high.
REQ-027 SHALL not route a response to the non-owner port under any rready combination.

Reset
REQ-028 SHALL on rst_n low immediately force IDLE, i_gnt=d_gnt=0, i_rvalid=d_rvalid=0, rdata=0, rom_addr=0 and the hold register to 0.
REQ-029 SHALL reset the last-granted pointer to the data port, so the first simultaneous request grants the fetch port.
REQ-030 SHALL discard any outstanding or held response when reset asserts mid-transaction; no rvalid after reset release without a new grant.

Verification
REQ-031 Fetch only, i_addr=0x080, i_rready=1 -> i_gnt same cycle, i_rvalid next cycle, rdata equals the ROM word at 0x080 (bench model 0xDEADC1B7).
REQ-032 i_req and d_req high from reset, both rready=1 -> grants alternate I,D,I,D, one per cycle, each rvalid one cycle after its grant.
REQ-033 Data read 0x15C with d_rready=0 for 3 cycles -> HOLD; d_rvalid and rdata=0x00FF00FF stable 3 cycles, no gnt asserted; d_rready=1 -> accepted, grants resume next cycle.
REQ-034 Fetch request in RESP with d_rready=1 on outstanding data response -> i_gnt in same cycle, back-to-back responses with no bubble.
REQ-035 rst_n low while in HOLD -> all outputs 0 asynchronously; after release, no rvalid until a new grant.
REQ-036 Granted port drops req the cycle after grant -> response still delivered once to that port only.
